// File: rtl/ucsbece154a_checker_pkg.sv
// rtl/ucsbece154a_checker_pkg.sv - shared types and constants for the commit checker
package ucsbece154a_checker_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;
  localparam int   REG_AW   = 5;
  localparam int   NREGS    = 1 << REG_AW;
endpackage

// File: rtl/ucsbece154a_halt_detect.sv
// rtl/ucsbece154a_halt_detect.sv - flags a halt once the PC has held still for HALT_CYCLES run cycles
module ucsbece154a_halt_detect #(
  parameter int XLEN        = 32,
  parameter int HALT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            start,
  input  logic            run,
  input  logic [XLEN-1:0] pc,
  output logic            halted
);
  localparam int            CW     = $clog2(HALT_CYCLES + 1);
  localparam logic [CW-1:0] HALT_L = CW'(HALT_CYCLES);

  logic [XLEN-1:0] prev_pc_q, prev_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // start seeds prev_pc so the first run cycle compares against the launch PC
  always_comb begin
    prev_pc_d = prev_pc_q;
    cnt_d     = cnt_q;
    if (clear) begin
      prev_pc_d = '0;
      cnt_d     = '0;
    end else if (start) begin
      prev_pc_d = pc;
      cnt_d     = '0;
    end else if (run) begin
      prev_pc_d = pc;
      if (pc != prev_pc_q)   cnt_d = '0;
      else if (cnt_q != HALT_L) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      prev_pc_q <= prev_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign halted = (cnt_q == HALT_L);
endmodule

// File: rtl/ucsbece154a_commit_checker.sv
// rtl/ucsbece154a_commit_checker.sv - shadows committed state and checks it against a preloaded expected list
module ucsbece154a_commit_checker
  import ucsbece154a_checker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NCHECK      = 16,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        exp_valid,
  output logic                        exp_ready,
  input  logic                        exp_kind,
  input  logic [XLEN-1:0]             exp_addr,
  input  logic [XLEN-1:0]             exp_data,
  input  logic                        start,
  input  logic [XLEN-1:0]             pc,
  input  logic                        rf_we,
  input  logic [REG_AW-1:0]           rf_addr,
  input  logic [XLEN-1:0]             rf_wdata,
  input  logic                        mem_we,
  input  logic [XLEN-1:0]             mem_addr,
  input  logic [XLEN-1:0]             mem_wdata,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [$clog2(NCHECK+1)-1:0] fail_count,
  output logic [$clog2(NCHECK)-1:0]   first_fail,
  output logic [XLEN-1:0]             cycle_count
);
  localparam int              LW        = $clog2(NCHECK + 1);
  localparam int              IW        = $clog2(NCHECK);
  localparam logic [LW-1:0]   NCHECK_L  = LW'(NCHECK);
  localparam logic [XLEN-1:0] MAX_L     = XLEN'(MAX_CYCLES);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  state_t            state_q, state_d;
  logic [LW-1:0]     loaded_q, loaded_d, idx_q, idx_d;
  logic [XLEN-1:0]   cyc_q, cyc_d;
  logic              timeout_q, timeout_d;
  logic [LW-1:0]     fail_count_q, fail_count_d;
  logic [IW-1:0]     first_fail_q, first_fail_d;
  logic [NCHECK-1:0] kind_q, kind_d, seen_q, seen_d;
  logic [XLEN-1:0]   addr_q [NCHECK], addr_d [NCHECK];
  logic [XLEN-1:0]   data_q [NCHECK], data_d [NCHECK];
  logic [XLEN-1:0]   obs_q [NCHECK], obs_d [NCHECK];
  logic [XLEN-1:0]   shadow_q [NREGS], shadow_d [NREGS];
  logic [IW-1:0]     ix;
  logic              entry_fail;
  logic              halted;

  assign ix = idx_q[IW-1:0];

  ucsbece154a_halt_detect #(.XLEN(XLEN), .HALT_CYCLES(HALT_CYCLES)) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .start  (state_q == ST_IDLE && start),
    .run    (state_q == ST_RUN),
    .pc     (pc),
    .halted (halted)
  );

  always_comb begin
    state_d      = state_q;
    loaded_d     = loaded_q;
    idx_d        = idx_q;
    cyc_d        = cyc_q;
    timeout_d    = timeout_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    kind_d       = kind_q;
    seen_d       = seen_q;
    addr_d       = addr_q;
    data_d       = data_q;
    obs_d        = obs_q;
    shadow_d     = shadow_q;
    entry_fail   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exp_valid && exp_ready) begin
          kind_d[loaded_q[IW-1:0]] = exp_kind;
          addr_d[loaded_q[IW-1:0]] = exp_addr;
          data_d[loaded_q[IW-1:0]] = exp_data;
          loaded_d                 = loaded_q + LW'(1);
        end
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rf_we && rf_addr != '0) shadow_d[rf_addr] = rf_wdata;
        // memory entries match on the word, so sub-word store addresses still hit
        if (mem_we) begin
          for (int i = 0; i < NCHECK; i++) begin
            if (kind_q[i] == KIND_MEM && (addr_q[i] & WORD_MASK) == (mem_addr & WORD_MASK)) begin
              seen_d[i] = 1'b1;
              obs_d[i]  = mem_wdata;
            end
          end
        end
        if (cyc_q != MAX_L) cyc_d = cyc_q + XLEN'(1);
        if (halted) begin
          state_d = ST_CHECK;
        end else if (cyc_d == MAX_L) begin
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (idx_q < loaded_q) begin
          if (kind_q[ix] == KIND_REG) entry_fail = (shadow_q[addr_q[ix][REG_AW-1:0]] != data_q[ix]);
          else                        entry_fail = !seen_q[ix] || (obs_q[ix] != data_q[ix]);
          if (entry_fail) begin
            if (fail_count_q == '0) first_fail_d = ix;
            fail_count_d = fail_count_q + LW'(1);
          end
        end
        if (idx_q + LW'(1) >= loaded_q) state_d = ST_DONE;
        else                            idx_d   = idx_q + LW'(1);
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d      = ST_IDLE;
      loaded_d     = '0;
      idx_d        = '0;
      cyc_d        = '0;
      timeout_d    = 1'b0;
      fail_count_d = '0;
      first_fail_d = '0;
      kind_d       = '0;
      seen_d       = '0;
      addr_d       = '{default: '0};
      data_d       = '{default: '0};
      obs_d        = '{default: '0};
      shadow_d     = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      loaded_q     <= '0;
      idx_q        <= '0;
      cyc_q        <= '0;
      timeout_q    <= 1'b0;
      fail_count_q <= '0;
      first_fail_q <= '0;
      kind_q       <= '0;
      seen_q       <= '0;
      addr_q       <= '{default: '0};
      data_q       <= '{default: '0};
      obs_q        <= '{default: '0};
      shadow_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      idx_q        <= idx_d;
      cyc_q        <= cyc_d;
      timeout_q    <= timeout_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      kind_q       <= kind_d;
      seen_q       <= seen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      obs_q        <= obs_d;
      shadow_q     <= shadow_d;
    end
  end

  assign exp_ready   = (state_q == ST_IDLE) && (loaded_q < NCHECK_L);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (fail_count_q == '0) && !timeout_q;
  assign timeout     = timeout_q;
  assign fail_count  = fail_count_q;
  assign first_fail  = first_fail_q;
  assign cycle_count = cyc_q;
endmodule

// File: tb/tb_ucsbece154a_commit_checker.sv
// tb/tb_ucsbece154a_commit_checker.sv - directed bench for the commit checker
module tb_ucsbece154a_commit_checker;
  logic        clk = 1'b0;
  logic        reset, clear, exp_valid, exp_ready, exp_kind, start;
  logic        rf_we, mem_we, done, pass, timeout;
  logic [31:0] exp_addr, exp_data, pc, rf_wdata, mem_addr, mem_wdata, cycle_count;
  logic [4:0]  rf_addr;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;
  int          n_vec = 0;
  int          n_err = 0;
  int          waited;

  ucsbece154a_commit_checker #(
    .XLEN(32), .NCHECK(16), .HALT_CYCLES(4), .MAX_CYCLES(32)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .pc(pc),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .pass(pass), .timeout(timeout), .fail_count(fail_count),
    .first_fail(first_fail), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic offer(input logic kind, input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_kind = kind; exp_addr = a; exp_data = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic step_reg(input logic [4:0] a, input logic [31:0] d);
    pc = pc + 32'd4; rf_we = 1'b1; rf_addr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic step_mem(input logic [31:0] a, input logic [31:0] d);
    pc = pc + 32'd4; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  // PC frozen: the core is spinning on jal x0,0
  task automatic wait_done();
    waited = 0;
    while (!done && waited < 200) begin
      tick();
      waited++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic load_std();
    offer(1'b0, 32'd2, 32'h0BEEF000);
    offer(1'b0, 32'd3, 32'h44);
    offer(1'b0, 32'd4, 32'h1);
    offer(1'b0, 32'd5, 32'hb);
    offer(1'b0, 32'd7, 32'h7);
    offer(1'b1, 32'h60, 32'h7);
    offer(1'b1, 32'h64, 32'h19);
    offer(1'b1, 32'h68, 32'h0BEEF000);
  endtask

  task automatic run_prog(input logic [31:0] t2val);
    step_reg(5'd2, 32'h0BEEF000);
    step_reg(5'd5, 32'h3);
    step_reg(5'd3, 32'h44);
    step_mem(32'h64, 32'h5);
    step_reg(5'd4, 32'h1);
    step_reg(5'd5, 32'hb);
    step_mem(32'h60, 32'h7);
    step_reg(5'd7, t2val);
    step_mem(32'h64, 32'h19);
    step_mem(32'h6A, 32'h0BEEF000);
    step_mem(32'h200, 32'h1234);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; clear = 1'b0; exp_valid = 1'b0; exp_kind = 1'b0; exp_addr = '0; exp_data = '0;
    start = 1'b0; pc = 32'h1000; rf_we = 1'b0; rf_addr = '0; rf_wdata = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    tick();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_exp_ready", {31'd0, exp_ready}, 32'd1);
    chk("rst_cycle_count", cycle_count, 32'd0);
    reset = 1'b1;
    tick();

    load_std();
    do_start();
    run_prog(32'h7);
    chk("t1_pass", {31'd0, pass}, 32'd1);
    chk("t1_fail_count", {27'd0, fail_count}, 32'd0);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);

    do_clear();
    chk("clr_done", {31'd0, done}, 32'd0);
    chk("clr_exp_ready", {31'd0, exp_ready}, 32'd1);
    load_std();
    do_start();
    run_prog(32'h8);
    chk("t2_pass", {31'd0, pass}, 32'd0);
    chk("t2_fail_count", {27'd0, fail_count}, 32'd1);
    chk("t2_first_fail", {28'd0, first_fail}, 32'd4);

    // unseen memory entry, offered in the same cycle as start
    do_clear();
    load_std();
    exp_valid = 1'b1; exp_kind = 1'b1; exp_addr = 32'h6C; exp_data = 32'h5; start = 1'b1;
    tick();
    exp_valid = 1'b0; start = 1'b0;
    run_prog(32'h7);
    chk("t3_pass", {31'd0, pass}, 32'd0);
    chk("t3_fail_count", {27'd0, fail_count}, 32'd1);
    chk("t3_first_fail", {28'd0, first_fail}, 32'd8);

    do_clear();
    do_start();
    waited = 0;
    while (!done && waited < 200) begin
      pc = pc + 32'd4;
      tick();
      waited++;
    end
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_timeout", {31'd0, timeout}, 32'd1);
    chk("t4_pass", {31'd0, pass}, 32'd0);
    chk("t4_cycle_count", cycle_count, 32'd32);

    do_clear();
    for (int i = 0; i < 17; i++) begin
      chk("t5_exp_ready", {31'd0, exp_ready}, (i < 16) ? 32'd1 : 32'd0);
      offer(1'b0, 32'd1, (i == 3) ? 32'h99 : ((i == 16) ? 32'h77 : 32'h5));
    end
    do_start();
    step_reg(5'd1, 32'h5);
    wait_done();
    chk("t5_fail_count", {27'd0, fail_count}, 32'd1);
    chk("t5_first_fail", {28'd0, first_fail}, 32'd3);

    // x0 stays zero, and monitor writes before start are ignored
    do_clear();
    rf_we = 1'b1; rf_addr = 5'd1; rf_wdata = 32'h99;
    tick();
    rf_we = 1'b0;
    offer(1'b0, 32'd0, 32'h0);
    offer(1'b0, 32'd1, 32'h0);
    do_start();
    step_reg(5'd0, 32'h123);
    wait_done();
    chk("t6_pass", {31'd0, pass}, 32'd1);
    chk("t6_fail_count", {27'd0, fail_count}, 32'd0);

    do_clear();
    offer(1'b0, 32'd1, 32'hDEAD);
    do_start();
    step_reg(5'd2, 32'h1);
    step_reg(5'd3, 32'h2);
    reset = 1'b0;
    tick();
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("mid_rst_fail_count", {27'd0, fail_count}, 32'd0);
    chk("mid_rst_first_fail", {28'd0, first_fail}, 32'd0);
    chk("mid_rst_cycle_count", cycle_count, 32'd0);
    chk("mid_rst_exp_ready", {31'd0, exp_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // zero entries after reset: halt takes 5 run cycles, then a single check cycle
    do_start();
    for (int i = 0; i < 5; i++) tick();
    chk("t7_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t7_done", {31'd0, done}, 32'd1);
    chk("t7_pass", {31'd0, pass}, 32'd1);
    chk("t7_cycle_count", cycle_count, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
